// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back sequencer: load sizes,
// the queued load descriptor and register-file geometry.
package wb_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    LD_BYTE = 2'd0,
    LD_HALF = 2'd1,
    LD_WORD = 2'd2
  } ld_size_e;

  // One outstanding load, captured at issue and consumed when its data returns
  typedef struct packed {
    logic [REG_AW-1:0] dest;
    ld_size_e          size;
    logic              is_signed;
    logic [1:0]        offset;
  } ld_desc_t;

endpackage : wb_pkg

// File: rtl/regfile_writeback_if.sv
// Execute/memory/decode side signals of the write-back sequencer plus the
// two register-file write ports it drives.
interface regfile_writeback_if;
  import wb_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_dest;
  logic [XLEN-1:0]   alu_data;

  logic              ld_issue_valid;
  logic              ld_issue_ready;
  logic [REG_AW-1:0] ld_dest;
  logic [1:0]        ld_size;
  logic              ld_signed;
  logic [1:0]        ld_offset;

  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  logic [REG_AW-1:0] read_addr_a;
  logic [REG_AW-1:0] read_addr_b;
  logic              hazard_a;
  logic              hazard_b;

  logic [REG_AW-1:0] write_addr_c;
  logic              write_enable_c;
  logic [XLEN-1:0]   write_data_c;
  logic [REG_AW-1:0] write_addr_d;
  logic              write_enable_d;
  logic [XLEN-1:0]   write_data_d;

  logic              protocol_error;

  // Pipeline / memory / decode side
  modport master (
    output alu_valid, alu_dest, alu_data,
    input  alu_ready,
    output ld_issue_valid, ld_dest, ld_size, ld_signed, ld_offset,
    input  ld_issue_ready,
    output mem_rvalid, mem_rdata,
    output read_addr_a, read_addr_b,
    input  hazard_a, hazard_b,
    input  write_addr_c, write_enable_c, write_data_c,
    input  write_addr_d, write_enable_d, write_data_d,
    input  protocol_error
  );

  // Write-back sequencer side
  modport slave (
    input  alu_valid, alu_dest, alu_data,
    output alu_ready,
    input  ld_issue_valid, ld_dest, ld_size, ld_signed, ld_offset,
    output ld_issue_ready,
    input  mem_rvalid, mem_rdata,
    input  read_addr_a, read_addr_b,
    output hazard_a, hazard_b,
    output write_addr_c, write_enable_c, write_data_c,
    output write_addr_d, write_enable_d, write_data_d,
    output protocol_error
  );

endinterface : regfile_writeback_if

// File: rtl/load_extract.sv
// Lane select and sign/zero extension of a little-endian memory word
// according to the size/offset/signedness of a load descriptor.
module load_extract
  import wb_pkg::*;
(
  input  ld_desc_t        desc_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] value_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (desc_i.offset)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
  end

  // Halfwords are naturally aligned: offset[0] does not affect the lane
  assign half_sel = desc_i.offset[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    value_c = word_i;
    case (desc_i.size)
      LD_BYTE: value_c = {{24{desc_i.is_signed & byte_sel[7]}}, byte_sel};
      LD_HALF: value_c = {{16{desc_i.is_signed & half_sel[15]}}, half_sel};
      default: value_c = word_i;
    endcase
  end

endmodule : load_extract

// File: rtl/regfile_writeback.sv
// Write-side sequencer for the dual-write register file: ALU results on port c,
// in-order load returns on port d, with a pending-load scoreboard for decode.
module regfile_writeback
  import wb_pkg::*;
#(
  parameter int unsigned LOAD_DEPTH = 4
) (
  input logic                clk,
  input logic                reset,
  regfile_writeback_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(LOAD_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  ld_desc_t            fifo_q [LOAD_DEPTH];

  logic                wec_q, wec_d;
  logic [REG_AW-1:0]   wac_q, wac_d;
  logic [XLEN-1:0]     wdc_q, wdc_d;
  logic                wed_q, wed_d;
  logic [REG_AW-1:0]   wad_q, wad_d;
  logic [XLEN-1:0]     wdd_q, wdd_d;
  logic                perr_q, perr_d;

  logic                fifo_empty;
  logic                fifo_full;
  logic                alu_fire;
  logic                ld_fire;
  logic                rsp_fire;
  logic                rsp_orphan;
  ld_desc_t            push_desc;
  ld_desc_t            head_desc;
  logic [XLEN-1:0]     ld_value;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                      (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

  assign bus.alu_ready      = reset && !pending_q[bus.alu_dest];
  assign bus.ld_issue_ready = reset && !fifo_full && !pending_q[bus.ld_dest];
  assign bus.hazard_a       = pending_q[bus.read_addr_a];
  assign bus.hazard_b       = pending_q[bus.read_addr_b];

  assign alu_fire   = bus.alu_valid && bus.alu_ready;
  assign ld_fire    = bus.ld_issue_valid && bus.ld_issue_ready;
  assign rsp_fire   = bus.mem_rvalid && !fifo_empty;
  assign rsp_orphan = bus.mem_rvalid && fifo_empty;

  assign push_desc = '{dest:      bus.ld_dest,
                       size:      ld_size_e'(bus.ld_size),
                       is_signed: bus.ld_signed,
                       offset:    bus.ld_offset};
  assign head_desc = fifo_q[rd_ptr_q[IDX_W-1:0]];

  load_extract u_extract (
    .desc_i  (head_desc),
    .word_i  (bus.mem_rdata),
    .value_c (ld_value)
  );

  // Next-state: pointers, scoreboard, write ports and sticky error
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pending_d = pending_q;
    wec_d     = 1'b0;
    wac_d     = wac_q;
    wdc_d     = wdc_q;
    wed_d     = 1'b0;
    wad_d     = wad_q;
    wdd_d     = wdd_q;
    perr_d    = perr_q || rsp_orphan;

    if (alu_fire) begin
      wec_d = (bus.alu_dest != REG_ZERO);
      wac_d = bus.alu_dest;
      wdc_d = bus.alu_data;
    end

    if (rsp_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      wed_d    = (head_desc.dest != REG_ZERO);
      wad_d    = head_desc.dest;
      wdd_d    = ld_value;
      pending_d[head_desc.dest] = 1'b0;
    end

    // Applied after the clear so a same-cycle issue leaves the bit pending
    if (ld_fire) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (bus.ld_dest != REG_ZERO) begin
        pending_d[bus.ld_dest] = 1'b1;
      end
    end

    pending_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pending_q <= '0;
      wec_q     <= 1'b0;
      wac_q     <= '0;
      wdc_q     <= '0;
      wed_q     <= 1'b0;
      wad_q     <= '0;
      wdd_q     <= '0;
      perr_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pending_q <= pending_d;
      wec_q     <= wec_d;
      wac_q     <= wac_d;
      wdc_q     <= wdc_d;
      wed_q     <= wed_d;
      wad_q     <= wad_d;
      wdd_q     <= wdd_d;
      perr_q    <= perr_d;
    end
  end

  // Descriptor storage needs no reset: the pointers define which entries are live
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      fifo_q[wr_ptr_q[IDX_W-1:0]] <= push_desc;
    end
  end

  assign bus.write_enable_c = wec_q;
  assign bus.write_addr_c   = wac_q;
  assign bus.write_data_c   = wdc_q;
  assign bus.write_enable_d = wed_q;
  assign bus.write_addr_d   = wad_q;
  assign bus.write_data_d   = wdd_q;
  assign bus.protocol_error = perr_q;

endmodule : regfile_writeback

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: scoreboard queues for ports c/d
// checked by a negedge monitor, plus point checks on hazards and readies.
module tb_regfile_writeback;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_writeback_if bus ();

  regfile_writeback #(.LOAD_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [4:0] dest;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] off;
  } mdesc_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  mdesc_t ld_q [$];
  wr_t    exp_c [$];
  wr_t    exp_d [$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference load extraction, written with shifts rather than lane muxes
  function automatic logic [31:0] model_ld(input logic [1:0] sz, input logic sg,
                                           input logic [1:0] off, input logic [31:0] w);
    logic [31:0] sh;
    case (sz)
      2'd0: begin
        sh = w >> {off, 3'b000};
        return sg ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      end
      2'd1: begin
        sh = off[1] ? (w >> 16) : w;
        return sg ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      end
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    wr_t e;
    if (bus.write_enable_c === 1'b1) begin
      if (exp_c.size() == 0) begin
        check("c_write_expected", 32'(bus.write_enable_c), 32'd0);
      end else begin
        e = exp_c.pop_front();
        check("c_addr", 32'(bus.write_addr_c), 32'(e.addr));
        check("c_data", bus.write_data_c, e.data);
      end
    end
    if (bus.write_enable_d === 1'b1) begin
      if (exp_d.size() == 0) begin
        check("d_write_expected", 32'(bus.write_enable_d), 32'd0);
      end else begin
        e = exp_d.pop_front();
        check("d_addr", 32'(bus.write_addr_d), 32'(e.addr));
        check("d_data", bus.write_data_d, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_wr(input logic [4:0] d, input logic [31:0] v);
    wr_t e;
    bus.alu_valid = 1'b1;
    bus.alu_dest  = d;
    bus.alu_data  = v;
    #1;
    check("alu_ready", 32'(bus.alu_ready), 32'd1);
    if (d != 5'd0) begin
      e.addr = d;
      e.data = v;
      exp_c.push_back(e);
    end
    step();
    bus.alu_valid = 1'b0;
  endtask

  task automatic ld_issue(input logic [4:0] d, input logic [1:0] sz, input logic sg,
                          input logic [1:0] off);
    mdesc_t m;
    bus.ld_issue_valid = 1'b1;
    bus.ld_dest        = d;
    bus.ld_size        = sz;
    bus.ld_signed      = sg;
    bus.ld_offset      = off;
    #1;
    check("ld_issue_ready", 32'(bus.ld_issue_ready), 32'd1);
    m.dest = d;
    m.size = sz;
    m.sgn  = sg;
    m.off  = off;
    ld_q.push_back(m);
    step();
    bus.ld_issue_valid = 1'b0;
  endtask

  task automatic push_resp_expect(input logic [31:0] w);
    mdesc_t m;
    wr_t    e;
    if (ld_q.size() != 0) begin
      m = ld_q.pop_front();
      if (m.dest != 5'd0) begin
        e.addr = m.dest;
        e.data = model_ld(m.size, m.sgn, m.off, w);
        exp_d.push_back(e);
      end
    end
  endtask

  task automatic resp(input logic [31:0] w);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = w;
    push_resp_expect(w);
    step();
    bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    mdesc_t m;
    wr_t    e;
    reset              = 1'b0;
    bus.alu_valid      = 1'b1;
    bus.alu_dest       = 5'd3;
    bus.alu_data       = 32'h1111_1111;
    bus.ld_issue_valid = 1'b1;
    bus.ld_dest        = 5'd4;
    bus.ld_size        = 2'd2;
    bus.ld_signed      = 1'b0;
    bus.ld_offset      = 2'd0;
    bus.mem_rvalid     = 1'b0;
    bus.mem_rdata      = '0;
    bus.read_addr_a    = 5'd0;
    bus.read_addr_b    = 5'd0;
    repeat (2) step();

    // Reset state
    check("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    check("rst_ld_ready", 32'(bus.ld_issue_ready), 32'd0);
    check("rst_wec", 32'(bus.write_enable_c), 32'd0);
    check("rst_wed", 32'(bus.write_enable_d), 32'd0);
    check("rst_wdc", bus.write_data_c, 32'd0);
    check("rst_wdd", bus.write_data_d, 32'd0);
    check("rst_perr", 32'(bus.protocol_error), 32'd0);
    bus.alu_valid      = 1'b0;
    bus.ld_issue_valid = 1'b0;
    reset              = 1'b1;
    step();

    // ALU writes: latency 1, r0 suppressed
    alu_wr(5'd5, 32'hDEAD_BEEF);
    check("wec_latency", 32'(bus.write_enable_c), 32'd1);
    check("wdc_r5", bus.write_data_c, 32'hDEAD_BEEF);
    alu_wr(5'd0, 32'h1234_5678);
    check("wec_r0", 32'(bus.write_enable_c), 32'd0);
    step();
    check("wec_pulse", 32'(bus.write_enable_c), 32'd0);

    // Load extraction variants
    ld_issue(5'd8, 2'd0, 1'b1, 2'd3);
    bus.read_addr_a = 5'd8;
    #1;
    check("hazard_a_r8", 32'(bus.hazard_a), 32'd1);
    resp(32'h80FF_1234);
    check("hazard_a_r8_clear", 32'(bus.hazard_a), 32'd0);
    check("wed_r8", 32'(bus.write_enable_d), 32'd1);
    check("byte_signed", bus.write_data_d, 32'hFFFF_FF80);
    ld_issue(5'd8, 2'd0, 1'b0, 2'd3);
    resp(32'h80FF_1234);
    check("byte_unsigned", bus.write_data_d, 32'h0000_0080);
    ld_issue(5'd10, 2'd1, 1'b0, 2'd2);
    resp(32'hBEEF_0001);
    check("half_unsigned", bus.write_data_d, 32'h0000_BEEF);
    ld_issue(5'd11, 2'd1, 1'b1, 2'd0);
    resp(32'h0000_8001);
    check("half_signed", bus.write_data_d, 32'hFFFF_8001);
    ld_issue(5'd12, 2'd1, 1'b1, 2'd3);
    resp(32'h7FFF_8000);
    ld_issue(5'd13, 2'd2, 1'b1, 2'd1);
    resp(32'h8765_4321);
    ld_issue(5'd0, 2'd2, 1'b0, 2'd0);
    resp(32'hCAFE_F00D);
    check("wed_r0", 32'(bus.write_enable_d), 32'd0);

    // Hazard and ALU blocking on a pending destination
    ld_issue(5'd9, 2'd2, 1'b0, 2'd0);
    bus.read_addr_a = 5'd9;
    bus.read_addr_b = 5'd9;
    bus.ld_dest     = 5'd9;
    bus.alu_valid   = 1'b1;
    bus.alu_dest    = 5'd9;
    bus.alu_data    = 32'h0000_0099;
    #1;
    check("hazard_b_r9", 32'(bus.hazard_b), 32'd1);
    check("ld_ready_pending", 32'(bus.ld_issue_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("hazard_a_r9", 32'(bus.hazard_a), 32'd1);
      check("alu_ready_blocked", 32'(bus.alu_ready), 32'd0);
      step();
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_2222;
    push_resp_expect(32'h1111_2222);
    #1;
    check("hazard_a_rsp_cycle", 32'(bus.hazard_a), 32'd1);
    check("alu_ready_rsp_cycle", 32'(bus.alu_ready), 32'd0);
    step();
    bus.mem_rvalid = 1'b0;
    check("hazard_a_after_wb", 32'(bus.hazard_a), 32'd0);
    check("alu_ready_after_wb", 32'(bus.alu_ready), 32'd1);
    e.addr = 5'd9;
    e.data = 32'h0000_0099;
    exp_c.push_back(e);
    step();
    bus.alu_valid   = 1'b0;
    bus.read_addr_a = 5'd0;
    bus.read_addr_b = 5'd0;

    // Fill the FIFO; a push alongside a pop while full is refused
    ld_issue(5'd1, 2'd2, 1'b0, 2'd0);
    ld_issue(5'd2, 2'd0, 1'b1, 2'd1);
    ld_issue(5'd3, 2'd1, 1'b0, 2'd2);
    ld_issue(5'd4, 2'd0, 1'b0, 2'd0);
    bus.ld_issue_valid = 1'b1;
    bus.ld_dest        = 5'd6;
    bus.ld_size        = 2'd2;
    bus.ld_signed      = 1'b0;
    bus.ld_offset      = 2'd0;
    #1;
    check("ld_ready_full", 32'(bus.ld_issue_ready), 32'd0);
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hA1A2_A3A4;
    push_resp_expect(32'hA1A2_A3A4);
    #1;
    check("ld_ready_full_pop", 32'(bus.ld_issue_ready), 32'd0);
    step();
    bus.mem_rvalid = 1'b0;
    check("ld_ready_after_pop", 32'(bus.ld_issue_ready), 32'd1);
    m.dest = 5'd6;
    m.size = 2'd2;
    m.sgn  = 1'b0;
    m.off  = 2'd0;
    ld_q.push_back(m);
    step();
    bus.ld_issue_valid = 1'b0;
    resp(32'hB1B2_B3F4);
    resp(32'hC1C2_C3C4);
    resp(32'hD1D2_D3D4);
    resp(32'hE1E2_E3E4);
    check("wdd_r6_last", bus.write_data_d, 32'hE1E2_E3E4);

    // Orphan response
    check("perr_before", 32'(bus.protocol_error), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_AAAA;
    step();
    bus.mem_rvalid = 1'b0;
    check("perr_set", 32'(bus.protocol_error), 32'd1);
    check("perr_no_write", 32'(bus.write_enable_d), 32'd0);
    step();
    check("perr_sticky", 32'(bus.protocol_error), 32'd1);

    // Reset mid-flight with two loads pending
    ld_issue(5'd14, 2'd2, 1'b0, 2'd0);
    ld_issue(5'd15, 2'd2, 1'b0, 2'd0);
    bus.read_addr_a = 5'd14;
    bus.read_addr_b = 5'd15;
    #1;
    check("hazard_a_r14", 32'(bus.hazard_a), 32'd1);
    check("hazard_b_r15", 32'(bus.hazard_b), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_hazard_a", 32'(bus.hazard_a), 32'd0);
    check("mid_rst_hazard_b", 32'(bus.hazard_b), 32'd0);
    check("mid_rst_perr", 32'(bus.protocol_error), 32'd0);
    check("mid_rst_wed", 32'(bus.write_enable_d), 32'd0);
    check("mid_rst_wdd", bus.write_data_d, 32'd0);
    check("mid_rst_wac", 32'(bus.write_addr_c), 32'd0);
    ld_q.delete();
    step();
    reset = 1'b1;
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h7777_7777;
    step();
    bus.mem_rvalid = 1'b0;
    check("post_rst_perr", 32'(bus.protocol_error), 32'd1);
    check("post_rst_no_write", 32'(bus.write_enable_d), 32'd0);

    repeat (3) step();
    check("exp_c_drained", 32'(exp_c.size()), 32'd0);
    check("exp_d_drained", 32'(exp_d.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_writeback

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side sequencer for the 32x32 dual-write register file. Drives write port c with ALU results and write port d with load results.
- Load results return in order from data memory. A scoreboard blocks read-after-write and write-after-write hazards on pending load destinations.
- Sits between execute/memory stages and register-file ports c/d. Decode stalls on its busy outputs.

Parameters:
- LOAD_DEPTH, 4, max outstanding loads; power of two, 2..16

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle
- alu_dest  in  5  destination register
- alu_data  in  32  result value
- ld_issue_valid  in  1  load issued to memory
- ld_issue_ready  out  1  load issue accepted
- ld_dest  in  5  load destination register
- ld_size  in  2  0=byte, 1=half, 2=word
- ld_signed  in  1  sign-extend byte/half
- ld_offset  in  2  address bits [1:0]
- mem_rvalid  in  1  memory read data valid (in order, no backpressure)
- mem_rdata  in  32  memory read word, little-endian lanes
- read_addr_a  in  5  decode source a
- read_addr_b  in  5  decode source b
- hazard_a  out  1  source a has pending load
- hazard_b  out  1  source b has pending load
- write_addr_c  out  5  to register file
- write_enable_c  out  1  to register file
- write_data_c  out  32  to register file
- write_addr_d  out  5  to register file
- write_enable_d  out  1  to register file
- write_data_d  out  32  to register file
- protocol_error  out  1  sticky: response with no outstanding load

Behaviour:
- Reset asserted (async): all write_* outputs 0, pending bits 0, FIFO empty, protocol_error 0. alu_ready and ld_issue_ready are 0 while reset is low.
- Scoreboard: 32 pending bits. Bit 0 is never set.
- hazard_x = pending[read_addr_x] (combinational), including the cycle the load writes back. Pending clears on the port-d write edge.
- alu_ready = !pending[alu_dest].
- ALU accept (valid&&ready): next edge registers write_enable_c=(alu_dest!=0), addr, data. Latency 1. write_enable_c pulses one cycle.
- ld_issue_ready = !full && !pending[ld_dest].
- Load accept: push {dest,size,signed,offset} into FIFO; set pending[ld_dest] if dest!=0.
- Load to r0 still occupies a FIFO entry but never writes.
- An ALU accept to a dest equal to a same-cycle accepted ld_dest is legal. The ALU write lands first; the load overwrites later.
- Response (mem_rvalid && !empty): pop head and extract.
  - byte: lane = offset.
  - half: lane pair = offset[1]; offset[0] is ignored.
  - word: offset is ignored.
  - Extend per ld_signed; word ignores ld_signed.
- Next edge after a response: write_enable_d=(dest!=0), addr, data, clear pending[dest]. Latency 1.
- Simultaneous pop and push: legal when full; the push is accepted only if not full before the pop (ready does not look ahead).
- Simultaneous c and d writes to the same address cannot occur, because the scoreboard blocks it.
- mem_rvalid with FIFO empty: data dropped, protocol_error set until reset.
- Same-cycle issue and set with a response clearing the same register: the set wins, leaving the bit pending.
- FIFO pointers are log2(LOAD_DEPTH)+1 bits and wrap naturally.
- Reset mid-operation: outstanding loads are discarded; later responses set protocol_error.

Decomposition:
- Package wb_pkg:
  - load-size enum (LD_BYTE, LD_HALF, LD_WORD)
  - load-descriptor struct {dest[4:0], size, signed, offset[1:0]}
  - REG_ZERO constant
- Sub-module load_extract: combinational lane select and extension (descriptor + word in, 32-bit value out).
- FIFO and scoreboard stay inline.

Test Plan:
- ALU write r5=0xDEADBEEF -> next cycle write_enable_c=1, addr 5, data 0xDEADBEEF. ALU write to r0 -> write_enable_c stays 0.
- Load byte signed, offset 3, into r8; response 0x80FF_1234 -> write_data_d=0xFFFFFF80 to r8. Same with unsigned -> 0x00000080.
- Half unsigned offset 2, response 0xBEEF_0001 -> 0x0000BEEF. Half signed offset 0, response 0x0000_8001 -> 0xFFFF8001.
- Issue load to r9, then read_addr_a=9 -> hazard_a=1 until write_enable_d edge. alu_valid to r9 held with alu_ready=0 until the load writes.
- Issue 4 loads (depth 4) -> ld_issue_ready=0. The fifth load is accepted only after a response. Responses return in issue order to the correct destinations.
- mem_rvalid with nothing outstanding -> protocol_error=1 and no write. Reset mid-flight with 2 loads pending -> hazards clear and outputs return to 0.
